// File: rtl/nn_sched_pkg.sv
// Shared types and default constants for the neural-network inference scheduler.
// The state enum is used by the top; the defaults seed the module parameters.
package nn_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_NNRST,
      S_FILL,
      S_RUN,
      S_DRAIN
   } nn_sched_state_t;

   localparam int DEF_N_CLIENTS = 2;
   localparam int DEF_N_IN      = 2;
   localparam int DEF_N_OUT     = 1;
   localparam int DEF_DW        = 8;
   localparam int DEF_TMO_W     = 12;

   // Width of an index into an n-entry table; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nn_sched_rr_arbiter.sv
// One-hot round-robin arbiter: the search starts just above the last winner and
// wraps to client 0. After reset the last winner is the top client, so client 0 wins first.
module nn_sched_rr_arbiter
   import nn_sched_pkg::*;
#(
   parameter int N = DEF_N_CLIENTS
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   logic [N-1:0] last_reg;
   logic [N-1:0] mask_hi;
   logic [N-1:0] req_hi;
   logic [N-1:0] pick_src;

   // Requests strictly above the last winner take priority; if there are none,
   // fall back to the lowest requester overall. x & -x isolates the lowest set bit.
   always_comb begin
      mask_hi  = ~((last_reg << 1) - N'(1));
      req_hi   = req & mask_hi;
      pick_src = (|req_hi) ? req_hi : req;
      grant    = pick_src & (~pick_src + N'(1));
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_reg <= {1'b1, {(N-1){1'b0}}};
      else if (advance && (|req))
         last_reg <= grant;
   end

endmodule

// File: rtl/nn_inference_scheduler.sv
// Time-shares one generated network between N_CLIENTS requesters: arbitrate, buffer inputs,
// reset/fill/run the network, return outputs. Define NN_SCHED_TIMEOUT_EN for the FILL/RUN watchdog.
module nn_inference_scheduler
   import nn_sched_pkg::*;
#(
   parameter  int N_CLIENTS = DEF_N_CLIENTS,
   parameter  int N_IN      = DEF_N_IN,
   parameter  int N_OUT     = DEF_N_OUT,
   parameter  int DW        = DEF_DW,
   parameter  int TMO_W     = DEF_TMO_W,
   localparam int AW        = cnt_w(N_IN)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CLIENTS-1:0] cli_req,
   output logic [N_CLIENTS-1:0] cli_grant,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   output logic                 in_ready,
   output logic                 res_valid,
   output logic signed [DW-1:0] res_data,
   output logic                 res_last,
   input  logic                 res_ready,
   output logic                 err,
   output logic                 nn_rst,
   output logic                 nn_fill,
   input  logic                 nn_ack_fill,
   input  logic                 nn_rd,
   input  logic [AW-1:0]        nn_rd_addr,
   output logic signed [DW-1:0] nn_in_data,
   output logic                 nn_req,
   input  logic                 nn_ack_network,
   input  logic                 nn_out_valid,
   input  logic signed [DW-1:0] nn_out_data
);

   localparam int IW = AW;
   localparam int OW = $clog2(N_OUT + 1);
   localparam int RW = cnt_w(N_OUT);

   if (N_CLIENTS < 2 || N_CLIENTS > 8 || N_IN < 1 || N_OUT < 1 || DW < 1 || TMO_W < 2) begin : g_bad_params
      $error("nn_inference_scheduler: parameter out of range");
   end

   nn_sched_state_t state_reg, state_next;

   logic [N_CLIENTS-1:0] grant_reg, grant_next, arb_grant;
   logic                 arb_advance;
   logic [IW-1:0]        icnt_reg, icnt_next;
   logic [OW-1:0]        ocnt_reg, ocnt_next;
   logic [RW-1:0]        rcnt_reg, rcnt_next;
   logic [AW-1:0]        rd_addr_reg;
   logic                 rst_hold_reg;
   logic                 ibuf_we, obuf_we;
   logic                 nn_rst_pulse;
   logic                 tmo_hit;
   logic                 owner_req;
   logic [N_IN-1:0]      ibuf_sel;
   logic [N_OUT-1:0]     obuf_sel;

   logic signed [DW-1:0] ibuf [N_IN];
   logic signed [DW-1:0] obuf [N_OUT];

   nn_sched_rr_arbiter #(
      .N (N_CLIENTS)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (cli_req),
      .advance (arb_advance),
      .grant   (arb_grant)
   );

   assign owner_req = |(cli_req & grant_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         grant_reg    <= '0;
         icnt_reg     <= '0;
         ocnt_reg     <= '0;
         rcnt_reg     <= '0;
         rd_addr_reg  <= '0;
         rst_hold_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         icnt_reg     <= icnt_next;
         ocnt_reg     <= ocnt_next;
         rcnt_reg     <= rcnt_next;
         rst_hold_reg <= 1'b0;
         if (nn_rd)
            rd_addr_reg <= nn_rd_addr;
      end
   end

   // Per-entry write selects keep every buffer index a compile-time constant.
   for (genvar gi = 0; gi < N_IN; gi++) begin : g_ibuf_sel
      assign ibuf_sel[gi] = ibuf_we && (icnt_reg == IW'(gi));
   end

   for (genvar gi = 0; gi < N_OUT; gi++) begin : g_obuf_sel
      assign obuf_sel[gi] = obuf_we && (ocnt_reg == OW'(gi));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_IN; i++)
         if (ibuf_sel[i])
            ibuf[i] <= in_data;
      for (int i = 0; i < N_OUT; i++)
         if (obuf_sel[i])
            obuf[i] <= nn_out_data;
   end

   // The network's read address is latched on nn_rd, so data follows one cycle later.
   always_comb begin
      nn_in_data = '0;
      for (int i = 0; i < N_IN; i++)
         if (rd_addr_reg == AW'(i))
            nn_in_data = ibuf[i];
   end

   always_comb begin
      res_data = '0;
      if (state_reg == S_DRAIN)
         for (int i = 0; i < N_OUT; i++)
            if (rcnt_reg == RW'(i))
               res_data = obuf[i];
   end

   assign res_last  = (state_reg == S_DRAIN) && (rcnt_reg == RW'(N_OUT - 1));
   assign cli_grant = grant_reg;
   assign nn_rst    = rst_hold_reg | nn_rst_pulse;
   assign err       = tmo_hit;

   always_comb begin
      state_next   = state_reg;
      grant_next   = grant_reg;
      icnt_next    = icnt_reg;
      ocnt_next    = ocnt_reg;
      rcnt_next    = rcnt_reg;
      arb_advance  = 1'b0;
      ibuf_we      = 1'b0;
      obuf_we      = 1'b0;
      in_ready     = 1'b0;
      res_valid    = 1'b0;
      nn_fill      = 1'b0;
      nn_req       = 1'b0;
      nn_rst_pulse = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (|cli_req) begin
               arb_advance = 1'b1;
               grant_next  = arb_grant;
               icnt_next   = '0;
               ocnt_next   = '0;
               rcnt_next   = '0;
               state_next  = S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            // A withdrawn request abandons the inference before the network is touched.
            if (!owner_req) begin
               grant_next = '0;
               icnt_next  = '0;
               state_next = S_IDLE;
            end else if (in_valid) begin
               ibuf_we = 1'b1;
               if (icnt_reg == IW'(N_IN - 1)) begin
                  icnt_next  = '0;
                  state_next = S_NNRST;
               end else begin
                  icnt_next = icnt_reg + 1'b1;
               end
            end
         end
         S_NNRST: begin
            nn_rst_pulse = 1'b1;
            state_next   = S_FILL;
         end
         S_FILL: begin
            nn_fill = 1'b1;
            if (nn_ack_fill)
               state_next = S_RUN;
         end
         S_RUN: begin
            nn_req = 1'b1;
            if (nn_out_valid && (ocnt_reg != OW'(N_OUT))) begin
               obuf_we   = 1'b1;
               ocnt_next = ocnt_reg + 1'b1;
            end
            if (nn_ack_network && (ocnt_reg == OW'(N_OUT))) begin
               rcnt_next  = '0;
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            res_valid = 1'b1;
            if (res_ready) begin
               if (rcnt_reg == RW'(N_OUT - 1)) begin
                  rcnt_next  = '0;
                  grant_next = '0;
                  state_next = S_IDLE;
               end else begin
                  rcnt_next = rcnt_reg + 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      if (tmo_hit) begin
         nn_rst_pulse = 1'b1;
         grant_next   = '0;
         state_next   = S_IDLE;
      end
   end

`ifdef NN_SCHED_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_reg;

   // Restarts on every state change, so FILL and RUN each get a full window.
   always_ff @(posedge clk) begin
      if (rst || (state_next != state_reg))
         tmo_reg <= '0;
      else if (state_reg == S_FILL || state_reg == S_RUN)
         tmo_reg <= tmo_reg + 1'b1;
   end

   assign tmo_hit = (state_reg == S_FILL || state_reg == S_RUN) && (&tmo_reg);
`else
   assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_nn_inference_scheduler.sv
// Directed bench: a small behavioural network answers sum(inputs)+5, and a vector table
// drives complete inferences; abort, reset-in-RUN and watchdog are hand-written sequences.
module tb_nn_inference_scheduler;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        cli_req = 2'b00;
   logic [1:0]        cli_grant;
   logic              in_valid = 1'b0;
   logic signed [7:0] in_data = 8'sd0;
   logic              in_ready;
   logic              res_valid;
   logic signed [7:0] res_data;
   logic              res_last;
   logic              res_ready = 1'b0;
   logic              err;
   logic              nn_rst;
   logic              nn_fill;
   logic              nn_ack_fill = 1'b0;
   logic              nn_rd = 1'b0;
   logic [0:0]        nn_rd_addr = 1'b0;
   logic signed [7:0] nn_in_data;
   logic              nn_req;
   logic              nn_ack_network = 1'b0;
   logic              nn_out_valid = 1'b0;
   logic signed [7:0] nn_out_data = 8'sd0;

   int checks = 0;
   int failures = 0;
   int rst_cycles = 0;
   int fill_cycles = 0;

   nn_inference_scheduler #(
      .N_CLIENTS (2),
      .N_IN      (2),
      .N_OUT     (1),
      .DW        (8),
      .TMO_W     (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cli_req        (cli_req),
      .cli_grant      (cli_grant),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .res_valid      (res_valid),
      .res_data       (res_data),
      .res_last       (res_last),
      .res_ready      (res_ready),
      .err            (err),
      .nn_rst         (nn_rst),
      .nn_fill        (nn_fill),
      .nn_ack_fill    (nn_ack_fill),
      .nn_rd          (nn_rd),
      .nn_rd_addr     (nn_rd_addr),
      .nn_in_data     (nn_in_data),
      .nn_req         (nn_req),
      .nn_ack_network (nn_ack_network),
      .nn_out_valid   (nn_out_valid),
      .nn_out_data    (nn_out_data)
   );

   always #5 clk = ~clk;

   // Behavioural network: reads both inputs, then on nn_req emits in0 + in1 + 5.
   logic signed [7:0] m_in [2];
   int   m_phase = 0;
   logic m_hang = 1'b0;

   always @(posedge clk) begin
      nn_rd        <= 1'b0;
      nn_out_valid <= 1'b0;
      if (nn_rst === 1'b1) begin
         m_phase        <= 0;
         nn_ack_fill    <= 1'b0;
         nn_ack_network <= 1'b0;
      end else begin
         case (m_phase)
            0: if (nn_fill === 1'b1) begin
                  nn_rd      <= 1'b1;
                  nn_rd_addr <= 1'b0;
                  m_phase    <= 1;
               end
            1: m_phase <= 2;
            2: begin
                  m_in[nn_rd_addr] <= nn_in_data;
                  if (nn_rd_addr == 1'b1) begin
                     nn_ack_fill <= 1'b1;
                     m_phase     <= 3;
                  end else begin
                     nn_rd      <= 1'b1;
                     nn_rd_addr <= nn_rd_addr + 1'b1;
                     m_phase    <= 1;
                  end
               end
            3: if (nn_req === 1'b1 && !m_hang) begin
                  nn_out_valid <= 1'b1;
                  nn_out_data  <= m_in[0] + m_in[1] + 8'sd5;
                  m_phase      <= 4;
               end
            4: begin
                  nn_ack_network <= 1'b1;
                  m_phase        <= 5;
               end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst && nn_rst === 1'b1) rst_cycles++;
      if (nn_fill === 1'b1) fill_cycles++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]        req;
      logic signed [7:0] a;
      logic signed [7:0] b;
      int                stall;
      logic [1:0]        exp_grant;
      logic signed [7:0] exp_out;
   } vec_t;

   vec_t vecs [6];

   task automatic load_words(input logic [1:0] req, input logic signed [7:0] a,
                             input logic signed [7:0] b, input logic [1:0] exp_grant,
                             input string tag);
      int n;
      n = 0;
      cli_req = req;
      while (cli_grant == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_grant"}, int'(cli_grant), int'(exp_grant));
      check({tag, "_in_ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = a;
      @(negedge clk);
      in_data = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_inference(input vec_t v, input string tag);
      int n;
      int rst0;
      int got;
      logic got_last;
      logic [1:0] g;
      n    = 0;
      rst0 = rst_cycles;
      load_words(v.req, v.a, v.b, v.exp_grant, tag);
      g = cli_grant;
      while (!res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_res_valid"}, int'(res_valid), 1);
      check({tag, "_nn_rst_pulses"}, rst_cycles - rst0, 1);
      for (int s = 0; s < v.stall; s++) begin
         check({tag, "_stall_valid"}, int'(res_valid), 1);
         check({tag, "_stall_data"}, int'(res_data), int'(v.exp_out));
         @(negedge clk);
      end
      res_ready = 1'b1;
      got       = int'(res_data);
      got_last  = res_last;
      check({tag, "_res_data"}, got, int'(v.exp_out));
      check({tag, "_res_last"}, int'(got_last), 1);
      @(negedge clk);
      res_ready = 1'b0;
      cli_req   = 2'b00;
      check({tag, "_valid_after"}, int'(res_valid), 0);
      check({tag, "_grant_after"}, int'(cli_grant), 0);
      $display("txn %s grant=%b in=%0d,%0d res=%0d last=%b stall=%0d", tag, g, v.a, v.b,
               got, got_last, v.stall);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [8:0] outs;
      int n;
      int fill0;
      int rst0;

      vecs[0] = '{2'b01, 8'sd5,   -8'sd3,  0, 2'b01, 8'sd7};
      vecs[1] = '{2'b11, 8'sd100, 8'sd27,  0, 2'b10, -8'sd124};
      vecs[2] = '{2'b11, 8'sd0,   8'sd0,   5, 2'b01, 8'sd5};
      vecs[3] = '{2'b11, 8'sd127, 8'sd127, 0, 2'b10, 8'sd3};
      vecs[4] = '{2'b11, -8'sd50, 8'sd20,  0, 2'b01, -8'sd25};
      vecs[5] = '{2'b10, 8'h80,   -8'sd1,  2, 2'b10, -8'sd124};

      // Reset state.
      repeat (3) @(negedge clk);
      outs = {cli_grant, in_ready, res_valid, res_last, err, nn_rst, nn_fill, nn_req};
      check("reset_outputs", int'(outs), int'(9'b00_0000100));
      check("reset_res_data", int'(res_data), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_nn_rst", int'(nn_rst), 0);
      $display("txn reset outs=%b", outs);

      for (int i = 0; i < 6; i++)
         do_inference(vecs[i], $sformatf("vec%0d", i));

      // Client 1 withdraws after one word: no network activity, pointer still moves on.
      fill0   = fill_cycles;
      rst0    = rst_cycles;
      n       = 0;
      cli_req = 2'b10;
      while (cli_grant == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_grant", int'(cli_grant), 2);
      in_valid = 1'b1;
      in_data  = 8'sd9;
      @(negedge clk);
      in_valid = 1'b0;
      cli_req  = 2'b00;
      @(negedge clk);
      check("abort_grant_drop", int'(cli_grant), 0);
      check("abort_in_ready", int'(in_ready), 0);
      repeat (5) @(negedge clk);
      check("abort_no_fill", fill_cycles - fill0, 0);
      check("abort_no_nn_rst", rst_cycles - rst0, 0);
      $display("txn abort client=1 fill_cycles=%0d", fill_cycles - fill0);
      do_inference('{2'b11, 8'sd1, 8'sd2, 0, 2'b01, 8'sd8}, "after_abort");

      // Reset while the network is running.
      m_hang = 1'b1;
      load_words(2'b01, 8'sd3, 8'sd4, 2'b01, "rst_run");
      n = 0;
      while (!nn_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_run_in_run", int'(nn_req), 1);
      rst     = 1'b1;
      cli_req = 2'b00;
      @(negedge clk);
      outs = {cli_grant, in_ready, res_valid, res_last, err, nn_rst, nn_fill, nn_req};
      check("rst_run_outputs", int'(outs), int'(9'b00_0000100));
      check("rst_run_res_data", int'(res_data), 0);
      rst    = 1'b0;
      m_hang = 1'b0;
      repeat (2) @(negedge clk);
      $display("txn rst_in_run outs=%b", outs);
      do_inference('{2'b11, -8'sd10, 8'sd4, 0, 2'b01, -8'sd1}, "after_rst");

`ifdef NN_SCHED_TIMEOUT_EN
      m_hang = 1'b1;
      load_words(2'b10, 8'sd1, 8'sd1, 2'b10, "tmo");
      n = 0;
      while (!nn_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("tmo_in_run", int'(nn_req), 1);
      n = 0;
      while (!err && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles", n, 15);
      check("tmo_nn_rst", int'(nn_rst), 1);
      check("tmo_no_result", int'(res_valid), 0);
      @(negedge clk);
      check("tmo_err_pulse", int'(err), 0);
      check("tmo_grant_drop", int'(cli_grant), 0);
      cli_req = 2'b00;
      m_hang  = 1'b0;
      repeat (2) @(negedge clk);
      $display("txn timeout cycles=%0d", n);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nn_inference_scheduler.md
# nn_inference_scheduler

Shares one generated neural-network instance (serial input fill port, `req`/`ack__network` run handshake, serial output strobe) between `N_CLIENTS` requesters. Grants one client per inference, round-robin, then buffers its input vector, resets and fills the network, runs it, captures the outputs and returns them to the owning client. Sits between the client-side request fabric and the network top module.

## Interface
- `N_CLIENTS`, default 2: number of requesters (2..8).
- `N_IN`, default 2: input words per inference.
- `N_OUT`, default 1: output words per inference.
- `DW`, default 8: signed data width.
- `TMO_W`, default 12: watchdog counter width (used only when `NN_SCHED_TIMEOUT_EN` is defined).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cli_req`  in  N_CLIENTS  per-client inference request, held until result completes.
- `cli_grant`  out  N_CLIENTS  one-hot owner of the network.
- `in_valid`  in  1  input word valid from the granted client.
- `in_data`  in  DW signed  input word.
- `in_ready`  out  1  scheduler accepts input word.
- `res_valid`  out  1  result word valid.
- `res_data`  out  DW signed  result word.
- `res_last`  out  1  final result word of the inference.
- `res_ready`  in  1  client accepts result word.
- `err`  out  1  one-cycle pulse on watchdog abort.
- `nn_rst`  out  1  network reset.
- `nn_fill`  out  1  network fill request.
- `nn_ack_fill`  in  1  network has consumed all inputs.
- `nn_rd`  in  1  network input read strobe.
- `nn_rd_addr`  in  clog2(N_IN)  network input address.
- `nn_in_data`  out  DW signed  `ibuf[nn_rd_addr]`.
- `nn_req`  out  1  network run request.
- `nn_ack_network`  in  1  network done (level).
- `nn_out_valid`  in  1  output word strobe.
- `nn_out_data`  in  DW signed  output word.

## Operation
- FSM: IDLE, LOAD, NNRST, FILL, RUN, DRAIN.
- IDLE: when any `cli_req` is set, grant the round-robin winner, searching from last-granted+1 (after reset, client 0 has top priority). Go to LOAD, clear counters.
- LOAD: `in_ready` = 1. Each `in_valid` stores into `ibuf[icnt]` and increments `icnt`. After word `N_IN-1` is stored, go to NNRST. If the granted `cli_req` drops, abort to IDLE with no network activity; the pointer still advances.
- NNRST: `nn_rst` = 1 for exactly one cycle, which clears the network's latched acks. Then go to FILL.
- FILL: `nn_fill` = 1 until `nn_ack_fill` is seen, then go to RUN.
- RUN: `nn_req` = 1. Each `nn_out_valid` writes `obuf[ocnt]`; `ocnt` saturates at `N_OUT`, and strobes beyond that are ignored. Go to DRAIN when `nn_ack_network` = 1 and `ocnt` = `N_OUT`.
- DRAIN: `res_data` = `obuf[rcnt]` and `res_valid` = 1. `rcnt` advances on `res_valid & res_ready`. `res_last` = 1 when `rcnt` = `N_OUT-1`. After the last transfer, drop `cli_grant` and return to IDLE.
- `cli_grant` is held from the IDLE exit through the end of DRAIN.
- Counters wrap at `N_IN`/`N_OUT` and never index out of range.
- Arithmetic is pass-through only; no sign extension or rescaling.

## Timing
- Reset values: `cli_grant`=0, `in_ready`=0, `res_valid`=0, `res_last`=0, `res_data`=0, `err`=0, `nn_rst`=1 (held during `rst`), `nn_fill`=0, `nn_req`=0. The RR pointer resets to the last client so client 0 wins first.
- Grant appears 1 cycle after `cli_req` is sampled in IDLE.
- `nn_in_data` is combinational from the registered `ibuf`, so it is valid the cycle after `nn_rd`.
- `nn_rst` pulse, then `nn_fill` on the next cycle.
- The minimum idle gap between consecutive inferences is 1 cycle (the IDLE arbitration cycle).
- Simultaneous `cli_req` changes during a grant have no effect until IDLE.
- `rst` mid-inference returns to IDLE next cycle, drops every output to its reset value and asserts `nn_rst`.

## Configuration
- `NN_SCHED_TIMEOUT_EN` defined: a `TMO_W`-bit counter clears on each state entry and counts in FILL and RUN.
  - On all-ones: pulse `err`, drive `nn_rst` for one cycle, drop the grant and return to IDLE.
  - No result is delivered for that inference.
- Undefined: no counter; `err` is tied to 0; FILL and RUN wait indefinitely.

## Structure
- `nn_sched_pkg`: state enum `nn_sched_state_t` and default parameter constants.
- Sub-module `nn_sched_rr_arbiter`: one-hot round-robin grant from the request vector and last grant, updated on an `advance` input.

## Test plan
- Client 0 alone, inputs 5 and -3; network model returns 7 → `res_data`=7 with `res_last`=1, one `nn_rst` pulse seen, `cli_grant` = 01 → 00.
- Both clients request continuously → grants alternate 01, 10, 01, 10 over 4 inferences.
- `res_ready` low for 5 cycles in DRAIN → `res_valid`/`res_data` held stable; single transfer when it rises.
- Client 1 drops `cli_req` after 1 input word → return to IDLE, `nn_fill` never asserts, next grant goes to client 0.
- `rst` asserted in RUN → next cycle: all outputs at reset values, `nn_req`=0, `nn_rst`=1.
- `NN_SCHED_TIMEOUT_EN` defined with `TMO_W`=4 and `nn_ack_network` never rising → `err` pulses 15 cycles after RUN entry, then IDLE.
